// File: rtl/nv_fifo_pkg.sv
// ----------------------------------------------------------------------------
// nv_fifo_pkg
//  Shared constants for the 64x10 valid/ready FIFO controller slice.
//  DEF_DEPTH / DEF_WIDTH / DEF_AW : default RAM geometry (DEPTH must be 2^AW)
//  SKID_DEPTH                     : entries in the output skid buffer
//  OCC_W                          : width of a total-occupancy count
//                                   (holds 0 .. DEPTH + SKID_DEPTH)
// ----------------------------------------------------------------------------
package nv_fifo_pkg;

    localparam int DEF_DEPTH  = 64;
    localparam int DEF_WIDTH  = 10;
    localparam int DEF_AW     = 6;
    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = DEF_AW + 2;

endpackage

// File: rtl/nv_fifo_ram_64x10.sv
// ----------------------------------------------------------------------------
// nv_fifo_ram_64x10
//  Two-port RAM model: one synchronous write port and one read port with a
//  registered read address. Data for an address presented with re=1 appears
//  on dout during the following cycle. Contents are not reset.
//  Ports:
//   clk           core clock
//   we/wa/di      write enable, write address, write data
//   re/ra         read enable, read address (captured at the clock edge)
//   dout          read data for the captured address
//   pwrbus_ram_pd power-control bus for the macro; unused by this model
// ----------------------------------------------------------------------------
module nv_fifo_ram_64x10
    import nv_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] di,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] dout,
    input  logic [31:0]      pwrbus_ram_pd
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra_q;
    logic             unused_pwrbus;

    // The behavioural model has no power states; the bus only reaches a macro.
    assign unused_pwrbus = ^pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= di;
        end
        if (re) begin
            ra_q <= ra;
        end
    end

    assign dout = mem[ra_q];

endmodule

// File: rtl/nv_fifo_rd_skid.sv
// ----------------------------------------------------------------------------
// nv_fifo_rd_skid
//  Two-entry in-order output buffer between the RAM read port and the
//  consumer. Absorbs the RAM read latency so the consumer sees a continuous
//  stream. Handshake: a word transfers out when rd_pvld & rd_prdy; a capture
//  (cap_vld) is always accepted because the issuer never lets
//  skid_cnt + words in flight exceed SKID_DEPTH.
//  Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   cap_vld/cap_pd word arriving from the RAM this cycle
//   rd_prdy       consumer ready
//   rd_pvld/rd_pd consumer valid and head-of-queue payload
//   skid_cnt      current number of buffered words (0..2)
// ----------------------------------------------------------------------------
module nv_fifo_rd_skid
    import nv_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_vld,
    input  logic [WIDTH-1:0] cap_pd,
    input  logic             rd_prdy,
    output logic             rd_pvld,
    output logic [WIDTH-1:0] rd_pd,
    output logic [1:0]       skid_cnt
);

    logic [WIDTH-1:0] ent0;   // head entry, drives rd_pd
    logic [WIDTH-1:0] ent1;   // second entry
    logic [1:0]       cnt;
    logic             pop;

    assign pop      = rd_pvld & rd_prdy;
    assign rd_pvld  = (cnt != 2'd0);
    assign rd_pd    = ent0;
    assign skid_cnt = cnt;

    // ent0 only changes when the head leaves or an empty buffer is filled,
    // so rd_pd is stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({cap_vld, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        ent0 <= cap_pd;
                    end else begin
                        ent1 <= cap_pd;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) begin
                        ent0 <= ent1;
                    end
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= cap_pd;
                    end else begin
                        ent0 <= cap_pd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nv_fifo_rws_64x10_ctl.sv
// ----------------------------------------------------------------------------
// nv_fifo_rws_64x10_ctl
//  Valid/ready FIFO controller around a 64x10 two-port RAM with a registered
//  read address, followed by a 2-entry output skid. Capacity DEPTH + 2 words.
//  Handshake: producer word transfers when wr_pvld & wr_prdy; consumer word
//  transfers when rd_pvld & rd_prdy. wr_prdy comes from registered state only.
//  Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   wr_pvld/wr_prdy/wr_pd  producer stream
//   rd_pvld/rd_prdy/rd_pd  consumer stream
//   pwrbus_ram_pd   RAM power bus, passed to the storage unmodified
//   fifo_lvl        registered total occupancy; present only when the
//                   NV_FIFO_LVL_EN macro is defined
// ----------------------------------------------------------------------------
module nv_fifo_rws_64x10_ctl
    import nv_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    input  logic [31:0]      pwrbus_ram_pd
`ifdef NV_FIFO_LVL_EN
    ,
    output logic [AW+1:0]    fifo_lvl
`endif
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      ram_cnt;     // committed words still in the RAM
    logic             inflight;    // read issued last cycle, data on dout now
    logic [1:0]       skid_cnt;
    logic [1:0]       rd_occ;
    logic             push;
    logic             rd_pop;
    logic             re;
    logic [WIDTH-1:0] ram_dout;

    assign wr_prdy = (ram_cnt != CNT_FULL);
    assign push    = wr_pvld & wr_prdy;
    assign rd_pop  = rd_pvld & rd_prdy;

    // Words already owed to the skid. A word leaving this cycle frees its
    // slot at the same edge the next read would land, so counting it as
    // free keeps the stream at one word per cycle without overfilling.
    assign rd_occ = skid_cnt + {1'b0, inflight};
    assign re     = (ram_cnt != '0) &&
                    ((rd_occ < 2'd2) || ((rd_occ == 2'd2) && rd_pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= re;
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (re) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push, re})
                2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
                2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

`ifdef NV_FIFO_LVL_EN
    localparam logic [AW+1:0] LVL_ONE = (AW+2)'(1);

    // Total = ram_cnt + inflight + skid_cnt; it only moves on a producer
    // accept or a consumer transfer, so track those directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_lvl <= '0;
        end else begin
            case ({push, rd_pop})
                2'b10:   fifo_lvl <= fifo_lvl + LVL_ONE;
                2'b01:   fifo_lvl <= fifo_lvl - LVL_ONE;
                default: fifo_lvl <= fifo_lvl;
            endcase
        end
    end
`endif

    nv_fifo_ram_64x10 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk           (clk),
        .we            (push),
        .wa            (wptr),
        .di            (wr_pd),
        .re            (re),
        .ra            (rptr),
        .dout          (ram_dout),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    nv_fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .cap_vld  (inflight),
        .cap_pd   (ram_dout),
        .rd_prdy  (rd_prdy),
        .rd_pvld  (rd_pvld),
        .rd_pd    (rd_pd),
        .skid_cnt (skid_cnt)
    );

endmodule

// File: tb/tb_nv_fifo_rws_64x10_ctl.sv
// ----------------------------------------------------------------------------
// tb_nv_fifo_rws_64x10_ctl
//  Self-checking bench: cycle vector table, directed multi-cycle sequences and
//  randomly throttled traffic checked against a queue model of the FIFO.
//  Define NV_FIFO_LVL_EN to also check the fifo_lvl port.
// ----------------------------------------------------------------------------
module tb_nv_fifo_rws_64x10_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_pvld = 1'b0;
    logic        wr_prdy;
    logic [9:0]  wr_pd = '0;
    logic        rd_pvld;
    logic        rd_prdy = 1'b0;
    logic [9:0]  rd_pd;
    logic [31:0] pwrbus_ram_pd = 32'h0;
`ifdef NV_FIFO_LVL_EN
    logic [7:0]  fifo_lvl;
`endif

    always #5 clk = ~clk;

    nv_fifo_rws_64x10_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .wr_pvld       (wr_pvld),
        .wr_prdy       (wr_prdy),
        .wr_pd         (wr_pd),
        .rd_pvld       (rd_pvld),
        .rd_prdy       (rd_prdy),
        .rd_pd         (rd_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
`ifdef NV_FIFO_LVL_EN
        ,
        .fifo_lvl      (fifo_lvl)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: ordered contents and total occupancy.
    logic [9:0] exp_q[$];
    int         occ = 0;
    int         pops_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        wr_pd = '0;
        exp_q.delete();
        occ = 0;
        pops_seen = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard: observe handshakes mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
`ifdef NV_FIFO_LVL_EN
            chk("fifo_lvl", 32'(fifo_lvl), 32'(occ));
`endif
            if (occ < 64) chk("wr_prdy_room", 32'(wr_prdy), 32'd1);
            else if (occ == 66) chk("wr_prdy_full", 32'(wr_prdy), 32'd0);
            if (rd_pvld && rd_prdy) begin
                pops_seen++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL pop_empty: got 0x%0h expected no word", rd_pd);
                end else begin
                    chk("rd_pd", 32'(rd_pd), 32'(exp_q.pop_front()));
                end
                occ--;
            end
            if (wr_pvld && wr_prdy) begin
                exp_q.push_back(wr_pd);
                occ++;
            end
        end
    end

    // Push n words base, base+1, ...; returns cycles taken.
    task automatic fill(input int n, input int base, output int cycles);
        int acc = 0;
        logic ok;
        cycles = 0;
        wr_pvld = 1'b1;
        while (acc < n && cycles < 400) begin
            wr_pd = 10'((base + acc) % 1024);
            ok = wr_prdy;
            step();
            if (ok) acc++;
            cycles++;
        end
        wr_pvld = 1'b0;
        chk("fill_count", 32'(acc), 32'(n));
    endtask

    task automatic drain(input int max_cyc);
        int c = 0;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        while ((exp_q.size() != 0 || rd_pvld) && c < max_cyc) begin
            step();
            c++;
        end
        rd_prdy = 1'b0;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic       wv;
        logic [9:0] wd;
        logic       rr;
        logic       e_wprdy;
        logic       e_pvld;
        logic [9:0] e_pd;
    } vec_t;

    vec_t vt[10];

    initial begin
        int cyc;
        int cnt;
        int gaps;
        int early;
        int wp;
        int rp;

        vt[0] = '{1'b1, 10'h155, 1'b0, 1'b1, 1'b0, 10'h000};
        vt[1] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000};
        vt[2] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h155};
        vt[3] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h155};
        vt[4] = '{1'b1, 10'h0AB, 1'b0, 1'b1, 1'b0, 10'h155};
        vt[5] = '{1'b1, 10'h3C0, 1'b0, 1'b1, 1'b0, 10'h155};
        vt[6] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h0AB};
        vt[7] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h0AB};
        vt[8] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h3C0};
        vt[9] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h3C0};

        // Reset values
        rst = 1'b1;
        step();
        chk("rst_wr_prdy", 32'(wr_prdy), 32'd1);
        chk("rst_rd_pvld", 32'(rd_pvld), 32'd0);
        chk("rst_rd_pd", 32'(rd_pd), 32'd0);
        do_reset();

        // Cycle table: latency, pop to empty, two-word skid fill and drain
        for (int i = 0; i < 10; i++) begin
            wr_pvld = vt[i].wv;
            wr_pd   = vt[i].wd;
            rd_prdy = vt[i].rr;
            step();
            chk($sformatf("vec%0d_wr_prdy", i), 32'(wr_prdy), 32'(vt[i].e_wprdy));
            chk($sformatf("vec%0d_rd_pvld", i), 32'(rd_pvld), 32'(vt[i].e_pvld));
            chk($sformatf("vec%0d_rd_pd", i), 32'(rd_pd), 32'(vt[i].e_pd));
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;

        // Fill 66 with consumer stalled, then gapless drain
        do_reset();
        fill(66, 0, cyc);
        chk("fill66_cycles", 32'(cyc), 32'd66);
        chk("full_wr_prdy", 32'(wr_prdy), 32'd0);
        rd_prdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 66; i++) begin
            if (rd_pvld) cnt++;
            step();
        end
        rd_prdy = 1'b0;
        chk("drain_gapless", 32'(cnt), 32'd66);
        chk("drain_pops", 32'(pops_seen), 32'd66);
        chk("after_drain_pvld", 32'(rd_pvld), 32'd0);

        // Streaming both sides for 200 cycles
        do_reset();
        rd_prdy = 1'b1;
        gaps = 0;
        early = 0;
        for (int k = 0; k < 200; k++) begin
            wr_pvld = 1'b1;
            wr_pd = 10'(k % 1024);
            if (k < 3 && rd_pvld) early++;
            if (k >= 3 && !rd_pvld) gaps++;
            step();
        end
        wr_pvld = 1'b0;
        chk("stream_fill_latency", 32'(early), 32'd0);
        chk("stream_gaps", 32'(gaps), 32'd0);
        repeat (4) step();
        chk("stream_pops", 32'(pops_seen), 32'd200);
        drain(10);

        // Full, then pop and push together
        do_reset();
        fill(66, 100, cyc);
        wr_pvld = 1'b1;
        wr_pd = 10'h3FF;
        rd_prdy = 1'b1;
        chk("full_pop_wr_prdy", 32'(wr_prdy), 32'd0);
        step();
        chk("full_pop_next_wr_prdy", 32'(wr_prdy), 32'd1);
        step();
        wr_pvld = 1'b0;
        drain(200);
        chk("full_pop_total", 32'(pops_seen), 32'd67);

        // Reset with a read in flight and one word in the skid
        do_reset();
        wr_pvld = 1'b1;
        wr_pd = 10'h111;
        step();
        wr_pd = 10'h222;
        step();
        wr_pvld = 1'b0;
        step();
        chk("pre_rst_pvld", 32'(rd_pvld), 32'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        occ = 0;
        #1;
        chk("async_rst_pvld", 32'(rd_pvld), 32'd0);
        chk("async_rst_wr_prdy", 32'(wr_prdy), 32'd1);
        chk("async_rst_pd", 32'(rd_pd), 32'd0);
        step();
        rst = 1'b0;
        wr_pvld = 1'b1;
        wr_pd = 10'h2AA;
        step();
        wr_pvld = 1'b0;
        chk("post_rst_e0", 32'(rd_pvld), 32'd0);
        step();
        chk("post_rst_e1", 32'(rd_pvld), 32'd0);
        step();
        chk("post_rst_e2_pvld", 32'(rd_pvld), 32'd1);
        chk("post_rst_e2_pd", 32'(rd_pd), 32'h2AA);
        drain(10);

`ifdef NV_FIFO_LVL_EN
        do_reset();
        fill(5, 7, cyc);
        repeat (3) step();
        rd_prdy = 1'b1;
        step();
        step();
        rd_prdy = 1'b0;
        chk("lvl_push5_pop2", 32'(fifo_lvl), 32'd3);
        drain(20);
`endif

        // Random throttling against the model
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin wp = 90; rp = 30; end
                1: begin wp = 30; rp = 90; end
                2: begin wp = 70; rp = 70; end
                default: begin wp = 50; rp = 50; end
            endcase
            for (int i = 0; i < 500; i++) begin
                wr_pvld = ($urandom_range(0, 99) < wp);
                wr_pd   = 10'($urandom_range(0, 1023));
                rd_prdy = ($urandom_range(0, 99) < rp);
                step();
            end
        end
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
